// File: rtl/hash_arbiter.sv
// Round-robin arbiter sharing one 40->8 XOR-fold hash among NUM_REQ requesters.
// Owns the output mask and drains the result slot before a new mask takes effect.
module hash_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IN_WIDTH  = 40,
    parameter int OUT_WIDTH = 8,
    parameter int TAG_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid_RnnH,
    input  logic [NUM_REQ*IN_WIDTH-1:0] req_data_RnnH,
    output logic [NUM_REQ-1:0]          req_ready_RnnH,
    input  logic                        mask_wr_RnnH,
    input  logic [OUT_WIDTH-1:0]        mask_wdata_RnnH,
    output logic                        mask_busy_RnnH,
    output logic                        rsp_valid_RnnH,
    input  logic                        rsp_ready_RnnH,
    output logic [OUT_WIDTH-1:0]        rsp_hash_RnnH,
    output logic [TAG_WIDTH-1:0]        rsp_tag_RnnH,
    output logic [15:0]                 hash_count_RnnH
);
    typedef enum logic [1:0] {RUN, DRAIN, UPDATE} state_t;

    state_t               state_q, state_d;
    logic [TAG_WIDTH-1:0] rr_ptr;
    logic [OUT_WIDTH-1:0] mask_q, mask_pend;
    logic                 slot_free, grant_any, grant;
    logic [TAG_WIDTH-1:0] grant_idx;
    logic [IN_WIDTH-1:0]  gdata;
    logic [39:0]          a;
    logic [7:0]           b0, b1, b2, b3, b4, c0, c1, c2, c3, e0, e1;
    logic [OUT_WIDTH-1:0] hash_raw;
    logic                 unused_bits;

    assign slot_free = !rsp_valid_RnnH || rsp_ready_RnnH;

    // Descending scan so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        int j;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid_RnnH[j]) begin
                grant_any = 1'b1;
                grant_idx = TAG_WIDTH'(j);
            end
        end
    end

    assign grant          = !rst && state_q == RUN && slot_free && grant_any;
    assign req_ready_RnnH = grant ? (NUM_REQ'(1) << grant_idx) : '0;

    assign gdata       = req_data_RnnH[grant_idx*IN_WIDTH +: IN_WIDTH];
    assign unused_bits = ^gdata[IN_WIDTH-1:34];
    assign a           = {3'b0, gdata[33:17], 3'b0, gdata[16:0]};
    assign {b4, b3, b2, b1, b0} = a;
    assign c0 = b0 ^ b1;
    assign c1 = b1 ^ b2;
    assign c2 = b2 ^ b3;
    assign c3 = b3 ^ b4;
    assign e0 = c0 ^ c2;
    assign e1 = c1 ^ c3;
    assign hash_raw = e0 ^ e1;

    assign mask_busy_RnnH = state_q != RUN;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (mask_wr_RnnH) state_d = DRAIN;
            DRAIN:   if (slot_free)    state_d = UPDATE;
            UPDATE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            rr_ptr          <= '0;
            mask_q          <= '1;
            mask_pend       <= '1;
            rsp_valid_RnnH  <= 1'b0;
            rsp_hash_RnnH   <= '0;
            rsp_tag_RnnH    <= '0;
            hash_count_RnnH <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                rsp_valid_RnnH <= 1'b1;
                rsp_hash_RnnH  <= hash_raw & mask_q;
                rsp_tag_RnnH   <= grant_idx;
                rr_ptr         <= TAG_WIDTH'((int'(grant_idx) + 1) % NUM_REQ);
                if (hash_count_RnnH != 16'hFFFF)
                    hash_count_RnnH <= hash_count_RnnH + 16'd1;
            end else if (rsp_ready_RnnH) begin
                rsp_valid_RnnH <= 1'b0;
            end
            if (mask_wr_RnnH)
                mask_pend <= mask_wdata_RnnH;
            // A write landing in UPDATE is the newest one, so it goes straight to the live mask.
            if (state_q == UPDATE)
                mask_q <= mask_wr_RnnH ? mask_wdata_RnnH : mask_pend;
        end
    end
endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter: handshake order, stall hold, mask drain, saturation, reset.
module tb_hash_arbiter;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*40-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            mask_wr;
    logic [7:0]      mask_wdata;
    logic            mask_busy;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_hash;
    logic [1:0]      rsp_tag;
    logic [15:0]     hash_count;

    int n_chk  = 0;
    int n_pass = 0;

    hash_arbiter #(.NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid_RnnH(req_valid), .req_data_RnnH(req_data), .req_ready_RnnH(req_ready),
        .mask_wr_RnnH(mask_wr), .mask_wdata_RnnH(mask_wdata), .mask_busy_RnnH(mask_busy),
        .rsp_valid_RnnH(rsp_valid), .rsp_ready_RnnH(rsp_ready), .rsp_hash_RnnH(rsp_hash),
        .rsp_tag_RnnH(rsp_tag), .hash_count_RnnH(hash_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input int i, input logic [39:0] v);
        req_data[i*40 +: 40] = v;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; mask_wr = 1'b0;
        mask_wdata = '0; rsp_ready = 1'b0;
        tick();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_count", hash_count, 0);
        chk("rst_busy", mask_busy, 0);
        chk("rst_hash", rsp_hash, 0);
        chk("rst_ready", req_ready, 0);
        rst = 1'b0;

        // single requester, mask all ones
        req_valid = 4'b0001; setd(0, 40'h00_0000_0001); rsp_ready = 1'b1;
        #1 chk("t1_ready", req_ready, 4'b0001);
        tick();
        chk("t1_valid", rsp_valid, 1);
        chk("t1_hash_a", rsp_hash, 8'h01);
        chk("t1_tag", rsp_tag, 0);
        setd(0, 40'h00_0001_0000);
        tick();
        chk("t1_hash_b", rsp_hash, 8'h00);
        setd(0, 40'h00_0000_0003);
        tick();
        chk("t1_hash_c", rsp_hash, 8'h03);
        chk("t1_count", hash_count, 3);

        // round robin under continuous rsp_ready
        rst = 1'b1; req_valid = '0;
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) setd(i, 40'(8'h10 + i));
        for (int i = 0; i < 8; i++) begin
            #1 chk("rr_ready", req_ready, 32'(1 << (i % 4)));
            tick();
            chk("rr_tag", rsp_tag, i % 4);
            chk("rr_hash", rsp_hash, 8'h10 + (i % 4));
        end
        chk("rr_count", hash_count, 8);

        // output stall holds the slot and blocks grants
        rsp_ready = 1'b0;
        #1 chk("stall_ready", req_ready, 0);
        tick();
        tick();
        chk("stall_valid", rsp_valid, 1);
        chk("stall_tag", rsp_tag, 3);
        chk("stall_hash", rsp_hash, 8'h13);
        rsp_ready = 1'b1;
        #1 chk("resume_ready", req_ready, 4'b0001);
        tick();
        chk("resume_tag", rsp_tag, 0);

        // mask change with stalled output
        req_valid = '0;
        tick();
        chk("idle_valid", rsp_valid, 0);
        req_valid = 4'b0001; setd(0, 40'hFF); rsp_ready = 1'b0;
        tick();
        chk("pre_hash", rsp_hash, 8'hFF);
        mask_wr = 1'b1; mask_wdata = 8'h0F;
        tick();
        mask_wr = 1'b0;
        chk("drain_busy", mask_busy, 1);
        #1 chk("drain_ready", req_ready, 0);
        tick();
        chk("drain_hash", rsp_hash, 8'hFF);
        chk("drain_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        #1 chk("drain_ready2", req_ready, 0);
        tick();
        chk("upd_valid", rsp_valid, 0);
        chk("upd_busy", mask_busy, 1);
        chk("upd_ready", req_ready, 0);
        tick();
        chk("run_busy", mask_busy, 0);
        #1 chk("run_ready", req_ready, 4'b0001);
        tick();
        chk("new_mask_hash", rsp_hash, 8'h0F);
        chk("new_mask_tag", rsp_tag, 0);

        // grant in the mask_wr cycle still uses the old mask
        mask_wr = 1'b1; mask_wdata = 8'hF0;
        tick();
        mask_wr = 1'b0;
        chk("oldmask_hash", rsp_hash, 8'h0F);
        chk("oldmask_busy", mask_busy, 1);
        tick();
        tick();
        chk("f0_busy", mask_busy, 0);
        tick();
        chk("f0_hash", rsp_hash, 8'hF0);

        // saturation of the issue counter
        rst = 1'b1;
        tick();
        rst = 1'b0; req_valid = 4'b1111;
        for (int n = 1; n <= 65540; n++) begin
            tick();
            if (n == 65534) chk("sat_fffe", hash_count, 16'hFFFE);
        end
        chk("sat_ffff", hash_count, 16'hFFFF);

        // reset while a drain is pending
        rsp_ready = 1'b0;
        tick();
        mask_wr = 1'b1; mask_wdata = 8'h00;
        tick();
        mask_wr = 1'b0;
        chk("mid_busy", mask_busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_valid", rsp_valid, 0);
        chk("mid_busy0", mask_busy, 0);
        chk("mid_count", hash_count, 0);
        rst = 1'b0; rsp_ready = 1'b1;
        #1 chk("mid_ready", req_ready, 4'b0001);
        tick();
        chk("mid_hash", rsp_hash, 8'hFF);
        chk("mid_tag", rsp_tag, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hash_arbiter.md
Name: hash_arbiter

Overview:
- Shares one 40-to-8 XOR-fold hash datapath among NUM_REQ sample-test requesters in the rasterizer.
- Arbitration is round-robin, one grant per cycle, with valid/ready handshakes on both sides.
- Registers the masked hash together with the requester tag.
- Owns the output mask register and drains in-flight work before a mask change takes effect.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IN_WIDTH, 40, hash input width (fixed at 40).
- OUT_WIDTH, 8, hash output width (fixed at 8).
- TAG_WIDTH, 2, requester index width, equal to $clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid_RnnH  in  NUM_REQ  per-requester valid.
- req_data_RnnH  in  NUM_REQ*IN_WIDTH  requester i data at [i*IN_WIDTH +: IN_WIDTH].
- req_ready_RnnH  out  NUM_REQ  one-hot grant; handshake completes when valid & ready.
- mask_wr_RnnH  in  1  one-cycle pulse requesting a mask update.
- mask_wdata_RnnH  in  OUT_WIDTH  new mask value.
- mask_busy_RnnH  out  1  high while a mask update is pending.
- rsp_valid_RnnH  out  1  result valid.
- rsp_ready_RnnH  in  1  downstream ready.
- rsp_hash_RnnH  out  OUT_WIDTH  masked hash.
- rsp_tag_RnnH  out  TAG_WIDTH  index of the requester that produced the result.
- hash_count_RnnH  out  16  count of issued hashes, saturating.

Behaviour:
- Hash function, combinational on the granted data d:
  - a = {3'b0, d[33:17], 3'b0, d[16:0]}, split into bytes b0..b4 (b0 = a[7:0]).
  - c0 = b0^b1, c1 = b1^b2, c2 = b2^b3, c3 = b3^b4.
  - e0 = c0^c2, e1 = c1^c3.
  - hash = (e0^e1) & mask_q.
  - d[39:34] is ignored.
- Output slot: a single register. slot_free = !rsp_valid_RnnH | rsp_ready_RnnH.
- Grant:
  - Only in state RUN and only when slot_free.
  - Grant goes to the first i, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ, with req_valid[i]=1.
  - req_ready is combinational and one-hot or zero. It must not depend on req_valid of the granted requester, except through the priority scan.
- On a grant to i, at the next edge:
  - rsp_hash <= hash(data_i).
  - rsp_tag <= i.
  - rsp_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - hash_count increments, saturating at 0xFFFF.
- Latency is 1 cycle from accept to rsp_valid. Throughput is one per cycle under continuous rsp_ready.
- rsp_valid falls when rsp_ready=1 and no new grant occurs in the same cycle.
- rsp_hash and rsp_tag hold stable while rsp_valid=1 and rsp_ready=0.
- If no requester is valid, rr_ptr is unchanged.
- FSM states: RUN, DRAIN, UPDATE.
  - RUN: on mask_wr, latch mask_wdata into mask_pend, set mask_busy, and go to DRAIN. A grant in that same cycle is still allowed and uses the old mask.
  - DRAIN: no grants. Go to UPDATE when rsp_valid=0, or when rsp_valid=1 & rsp_ready=1.
  - UPDATE: mask_q <= mask_pend, clear mask_busy, return to RUN. No grant in this cycle.
  - mask_wr while mask_busy=1 overwrites mask_pend; the last write wins, and the state is unchanged.
- Reset, synchronous and overriding everything:
  - State RUN, rr_ptr=0, mask_q=all ones, mask_pend=all ones.
  - rsp_valid=0, rsp_hash=0, rsp_tag=0, hash_count=0, mask_busy=0.
  - req_ready=0 during the reset cycle.
- Reset mid-operation discards any pending response and any pending mask without a handshake.

Test Plan:
- Single requester, mask 0xFF:
  - req0 data 0x00_0000_0001 -> rsp_hash 0x01, tag 0, one cycle after accept.
  - data 0x00_0001_0000 -> 0x00.
  - data 0x00_0000_0003 -> 0x03.
- All 4 valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,... one per cycle; hash_count = 8 after 8 cycles.
- rsp_ready=0 with rsp_valid=1 -> all req_ready=0; rsp_hash and rsp_tag held. rsp_ready high again -> the next grant resumes at rr_ptr without skipping a requester.
- Mask change:
  - data 0xFF, then mask_wr 0x0F with stalled output -> mask_busy=1 and no grants until drain.
  - After UPDATE, data 0xFF -> rsp_hash 0x0F.
  - A result issued before the write still shows 0xFF.
- hash_count preloaded near saturation by 65,540 grants -> reads 0xFFFF and does not wrap.
- Assert rst while rsp_valid=1 and DRAIN is pending -> the next cycle shows rsp_valid=0, mask_busy=0, mask 0xFF, first grant to requester 0.
